// File: rtl/reduction_table_engine_if.sv
// reduction_table_engine_if: packet input, result output and error pulse bundle
interface reduction_table_engine_if #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int CHILD_W = 3,
    parameter int OP_W    = 4,
    parameter int ADDR_W  = 9
);
    logic               in_valid;
    logic               in_ready;
    logic [TAG_W-1:0]   in_tag;
    logic [CHILD_W-1:0] in_children;
    logic [OP_W-1:0]    in_op;
    logic [ADDR_W-1:0]  in_dst;
    logic [DATA_W-1:0]  in_payload;
    logic               out_valid;
    logic               out_ready;
    logic [TAG_W-1:0]   out_tag;
    logic [ADDR_W-1:0]  out_dst;
    logic [ADDR_W-1:0]  out_src;
    logic [DATA_W-1:0]  out_payload;
    logic               err;

    modport slave (
        input  in_valid, in_tag, in_children, in_op, in_dst, in_payload, out_ready,
        output in_ready, out_valid, out_tag, out_dst, out_src, out_payload, err
    );

    modport master (
        output in_valid, in_tag, in_children, in_op, in_dst, in_payload, out_ready,
        input  in_ready, out_valid, out_tag, out_dst, out_src, out_payload, err
    );
endinterface

// File: rtl/reduction_table_engine.sv
// reduction_table_engine: tagged reduction table with pipelined combine and single output register
module reduction_table_engine #(
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 3,
    parameter int CHILD_W = 3,
    parameter int OP_W    = 4,
    parameter int ADDR_W  = 9,
    parameter int ALU_LAT = 4,
    parameter logic [ADDR_W-1:0] RANK = 9'd0
) (
    input logic clk,
    input logic rst,
    reduction_table_engine_if.slave bus
);
    localparam int DEPTH = 2**TAG_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, BUSY, DONE} ent_state_t;

    ent_state_t         state     [DEPTH];
    ent_state_t         state_nxt [DEPTH];
    logic [OP_W-1:0]    op_q      [DEPTH];
    logic [ADDR_W-1:0]  dst_q     [DEPTH];
    logic [CHILD_W-1:0] rem_q     [DEPTH];
    logic [DATA_W-1:0]  part_q    [DEPTH];

    logic               p_valid [ALU_LAT];
    logic [TAG_W-1:0]   p_tag   [ALU_LAT];
    logic [DATA_W-1:0]  p_data  [ALU_LAT];

    ent_state_t         cur;
    logic               accept, alloc, issue, mism, wb, load, found;
    logic [TAG_W-1:0]   sel, wb_tag;

    function automatic logic [DATA_W-1:0] combine(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [OP_W-1:0]   op
    );
        case (op)
            0:       return a + b;
            1:       return ($signed(a) > $signed(b)) ? a : b;
            2:       return ($signed(a) < $signed(b)) ? a : b;
            3:       return a & b;
            4:       return a | b;
            5:       return a ^ b;
            default: return a;
        endcase
    endfunction

    assign cur          = state[bus.in_tag];
    assign bus.in_ready = (cur == IDLE) || (cur == ACTIVE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign alloc        = accept && (cur == IDLE);
    assign issue        = accept && (cur == ACTIVE) && (bus.in_op == op_q[bus.in_tag]);
    assign mism         = accept && (cur == ACTIVE) && (bus.in_op != op_q[bus.in_tag]);
    assign wb           = p_valid[ALU_LAT-1];
    assign wb_tag       = p_tag[ALU_LAT-1];
    assign load         = found && (!bus.out_valid || bus.out_ready);
    assign bus.out_src  = RANK;

    // pick the lowest-index DONE entry for the output register
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state[i] == DONE) begin
                found = 1'b1;
                sel   = TAG_W'(i);
            end
        end
    end

    // entry state transitions; accept, writeback and load always hit distinct entries
    always_comb begin
        state_nxt = state;
        if (alloc) state_nxt[bus.in_tag] = (bus.in_children == '0) ? DONE : ACTIVE;
        if (issue) state_nxt[bus.in_tag] = BUSY;
        if (wb)    state_nxt[wb_tag]     = (rem_q[wb_tag] == '0) ? DONE : ACTIVE;
        if (load)  state_nxt[sel]        = IDLE;
    end

    // entry state register
    always_ff @(posedge clk) begin
        if (rst) foreach (state[i]) state[i] <= IDLE;
        else     state <= state_nxt;
    end

    // table payload fields: allocation, remaining-count decrement and combine writeback
    always_ff @(posedge clk) begin
        if (alloc) begin
            op_q[bus.in_tag]   <= bus.in_op;
            dst_q[bus.in_tag]  <= bus.in_dst;
            rem_q[bus.in_tag]  <= bus.in_children;
            part_q[bus.in_tag] <= bus.in_payload;
        end
        if (issue) rem_q[bus.in_tag] <= rem_q[bus.in_tag] - CHILD_W'(1);
        if (wb)    part_q[wb_tag]    <= p_data[ALU_LAT-1];
    end

    // combine pipeline: result computed at issue, then delayed so it lands ALU_LAT edges later
    always_ff @(posedge clk) begin
        p_valid[0] <= issue && !rst;
        p_tag[0]   <= bus.in_tag;
        p_data[0]  <= combine(part_q[bus.in_tag], bus.in_payload, bus.in_op);
        for (int i = 1; i < ALU_LAT; i++) begin
            p_valid[i] <= p_valid[i-1] && !rst;
            p_tag[i]   <= p_tag[i-1];
            p_data[i]  <= p_data[i-1];
        end
    end

    // output register held until handshake, plus the dropped-packet error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_tag     <= '0;
            bus.out_dst     <= '0;
            bus.out_payload <= '0;
            bus.err         <= 1'b0;
        end else begin
            bus.err <= mism;
            if (load) begin
                bus.out_valid   <= 1'b1;
                bus.out_tag     <= sel;
                bus.out_dst     <= dst_q[sel];
                bus.out_payload <= part_q[sel];
            end else if (bus.out_ready) begin
                bus.out_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reduction_table_engine.sv
// tb_reduction_table_engine: directed and randomized checks against a per-tag reduction model
module tb_reduction_table_engine;
    localparam int LAT = 4;
    localparam logic [8:0] RANK = 9'h0A5;

    typedef struct {
        logic [2:0]  tag;
        logic [8:0]  dst;
        logic [31:0] pay;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    logic hold_v = 1'b0;
    logic [43:0] hold_val;
    int   mk;

    res_t        exp_q [$];
    logic [2:0]  hs_tag [$];
    int          hs_cyc [$];
    bit          m_open [8];
    logic [3:0]  m_op   [8];
    logic [8:0]  m_dst  [8];
    int          m_left [8];
    logic [31:0] m_acc  [8];

    always #5 clk = ~clk;

    reduction_table_engine_if bus ();

    reduction_table_engine #(.ALU_LAT(LAT), .RANK(RANK)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            0:       return a + b;
            1:       return (sa >= sb) ? a : b;
            2:       return (sa <= sb) ? a : b;
            3:       return a & b;
            4:       return a | b;
            5:       return a ^ b;
            default: return a;
        endcase
    endfunction

    task automatic model_reset();
        foreach (m_open[i]) m_open[i] = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [2:0] t, input int ch, input logic [3:0] op,
                                input logic [8:0] dst, input logic [31:0] pay, output bit mism);
        mism = 1'b0;
        if (!m_open[t]) begin
            if (ch == 0) exp_q.push_back('{t, dst, pay});
            else begin
                m_open[t] = 1'b1;
                m_op[t]   = op;
                m_dst[t]  = dst;
                m_left[t] = ch;
                m_acc[t]  = pay;
            end
        end else if (op != m_op[t]) begin
            mism = 1'b1;
        end else begin
            m_acc[t] = ref_op(op, m_acc[t], pay);
            m_left[t]--;
            if (m_left[t] == 0) begin
                m_open[t] = 1'b0;
                exp_q.push_back('{t, m_dst[t], m_acc[t]});
            end
        end
    endtask

    task automatic send(input logic [2:0] t, input int ch, input logic [3:0] op,
                        input logic [8:0] dst, input logic [31:0] pay);
        int n = 0;
        bit mism;
        bus.in_valid    = 1'b1;
        bus.in_tag      = t;
        bus.in_children = 3'(ch);
        bus.in_op       = op;
        bus.in_dst      = dst;
        bus.in_payload  = pay;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            check("send_timeout", 64'(n), 0);
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        model_accept(t, ch, op, dst, pay, mism);
        check("err", bus.err, mism);
    endtask

    task automatic stall_len(input logic [2:0] t, output int n);
        n = 0;
        bus.in_tag = t;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input logic [2:0] t, input logic [31:0] exp);
        int n = 0;
        bit got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.out_valid && bus.out_ready && bus.out_tag == t) begin
                got = 1'b1;
                check($sformatf("result_t%0d", t), bus.out_payload, exp);
            end
        end
        check("result_seen", got, 1);
        @(posedge clk);
        #1;
    endtask

    // count cycles for handshake spacing checks
    always @(posedge clk) cyc++;

    // randomized downstream backpressure
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // output monitor: scoreboard match, hold stability while stalled
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_v) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_fields", {bus.out_tag, bus.out_dst, bus.out_payload}, hold_val);
            end
            if (bus.out_valid && bus.out_ready) begin
                mk = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (mk < 0 && exp_q[i].tag == bus.out_tag) mk = i;
                check("out_known", mk >= 0, 1);
                if (mk >= 0) begin
                    check("out_dst", bus.out_dst, exp_q[mk].dst);
                    check("out_payload", bus.out_payload, exp_q[mk].pay);
                    exp_q.delete(mk);
                end
                check("out_src", bus.out_src, RANK);
                hs_tag.push_back(bus.out_tag);
                hs_cyc.push_back(cyc);
            end
        end
        hold_v   = !rst && bus.out_valid && !bus.out_ready;
        hold_val = {bus.out_tag, bus.out_dst, bus.out_payload};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0] t;
        bus.in_valid    = 1'b0;
        bus.in_tag      = '0;
        bus.in_children = '0;
        bus.in_op       = '0;
        bus.in_dst      = '0;
        bus.in_payload  = '0;
        bus.out_ready   = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_err", bus.err, 0);
            check("rst_out_fields", {bus.out_tag, bus.out_dst, bus.out_payload}, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.in_tag = 3'(i);
            #1;
            check("ready_after_rst", bus.in_ready, 1);
        end
        @(posedge clk);
        #1;

        send(3'd2, 0, 4'd0, 9'h011, 32'd7);
        check("leaf_early", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("leaf_valid", bus.out_valid, 1);
        check("leaf_tag", bus.out_tag, 2);
        check("leaf_payload", bus.out_payload, 7);
        check("leaf_src", bus.out_src, RANK);

        send(3'd1, 2, 4'd0, 9'h022, 32'd5);
        stall_len(3'd1, n);
        check("stall_alloc", 64'(n), 0);
        send(3'd1, 0, 4'd0, 9'h022, 32'd10);
        stall_len(3'd1, n);
        check("stall_combine", 64'(n), LAT);
        send(3'd1, 0, 4'd0, 9'h022, 32'd20);
        wait_result(3'd1, 32'd35);

        send(3'd3, 2, 4'd1, 9'h033, 32'hFFFF_FFFD);
        send(3'd3, 0, 4'd1, 9'h033, 32'd8);
        send(3'd3, 0, 4'd1, 9'h033, 32'hFFFF_FFF7);
        wait_result(3'd3, 32'd8);
        send(3'd4, 2, 4'd2, 9'h044, 32'hFFFF_FFFD);
        send(3'd4, 0, 4'd2, 9'h044, 32'd8);
        send(3'd4, 0, 4'd2, 9'h044, 32'hFFFF_FFF7);
        wait_result(3'd4, 32'hFFFF_FFF7);
        send(3'd5, 1, 4'd0, 9'h055, 32'hFFFF_FFFF);
        send(3'd5, 0, 4'd0, 9'h055, 32'd2);
        wait_result(3'd5, 32'd1);

        bus.out_ready = 1'b0;
        hs_tag.delete();
        hs_cyc.delete();
        send(3'd0, 0, 4'd0, 9'h001, 32'd11);
        send(3'd7, 0, 4'd0, 9'h002, 32'd22);
        send(3'd6, 0, 4'd0, 9'h003, 32'd33);
        repeat (5) @(posedge clk);
        #1;
        check("bp_valid", bus.out_valid, 1);
        check("bp_tag", bus.out_tag, 0);
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("bp_count", hs_tag.size(), 3);
        if (hs_tag.size() == 3) begin
            check("bp_order0", hs_tag[0], 0);
            check("bp_order1", hs_tag[1], 6);
            check("bp_order2", hs_tag[2], 7);
            check("bp_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 1);
            check("bp_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 1);
        end

        send(3'd0, 2, 4'd0, 9'h005, 32'd1);
        send(3'd0, 0, 4'd3, 9'h005, 32'd100);
        @(posedge clk);
        #1;
        check("err_clear", bus.err, 0);
        send(3'd0, 0, 4'd0, 9'h005, 32'd2);
        send(3'd0, 0, 4'd0, 9'h005, 32'd4);
        wait_result(3'd0, 32'd7);

        send(3'd1, 1, 4'd0, 9'h006, 32'd50);
        send(3'd1, 0, 4'd0, 9'h006, 32'd60);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_mid_valid", bus.out_valid, 0);
        bus.in_tag = 3'd1;
        #1;
        check("rst_mid_ready", bus.in_ready, 1);
        repeat (LAT + 3) @(posedge clk);
        #1;
        check("rst_flush", bus.out_valid, 0);
        send(3'd1, 1, 4'd0, 9'h006, 32'd3);
        send(3'd1, 0, 4'd0, 9'h006, 32'd4);
        wait_result(3'd1, 32'd7);

        rand_rdy = 1'b1;
        repeat (300) begin
            t = 3'($urandom_range(0, 7));
            if (m_open[t])
                send(t, 0, ($urandom_range(0, 7) == 0) ? m_op[t] ^ 4'h1 : m_op[t], 9'h000, $urandom());
            else
                send(t, $urandom_range(0, 3), 4'($urandom_range(0, 7)), 9'($urandom()), $urandom());
        end
        for (int i = 0; i < 8; i++)
            while (m_open[i]) send(3'(i), 0, m_op[i], 9'h000, $urandom());
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
